// File: rtl/ft_pkg.sv
// Shared types for the N-modular-redundancy fault-tolerance block.
// - ft_state_e : recovery sequencer states
// - vote_t     : result of comparing the per-core writeback tuples
package ft_pkg;

  // The voter is written for at most three cores; masks are sized for that.
  localparam int MAX_CORES = 3;

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    HALT   = 3'd1,
    RESET  = 3'd2,
    REPLAY = 3'd3,
    RESUME = 3'd4
  } ft_state_e;

  // agree         : every core presented the same tuple
  // majority_idx  : a core whose tuple is the agreed/majority one
  // minority_mask : one-hot of the outvoted core (TMR with a majority only)
  // uncorrectable : TMR with all three tuples different
  typedef struct packed {
    logic                 agree;
    logic [1:0]           majority_idx;
    logic [MAX_CORES-1:0] minority_mask;
    logic                 uncorrectable;
  } vote_t;

endpackage

// File: rtl/ft_voter.sv
// Combinational tuple voter for 2 (DMR) or 3 (TMR) redundant cores.
// Ports:
// - we   : per-core GPR write enable
// - addr : per-core GPR address, core k at [k*ADDR_WIDTH +: ADDR_WIDTH]
// - data : per-core GPR data, same packing (ignored when that core's we=0)
// - pc   : per-core retired PC, same packing
// - vote : agreement / majority / minority / uncorrectable summary
module ft_voter
  import ft_pkg::*;
#(
  parameter int NUM_CORES  = 3,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic [NUM_CORES-1:0]            we,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] data,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] pc,
  output vote_t                           vote
);

  localparam int TUPLE_W = 1 + ADDR_WIDTH + 2 * DATA_WIDTH;

  logic [TUPLE_W-1:0] tuple [NUM_CORES];

  // Data is masked when the core does not write, so stale data on an idle
  // port can never cause a disagreement.
  always_comb begin
    for (int k = 0; k < NUM_CORES; k++) begin
      tuple[k] = {we[k],
                  addr[k*ADDR_WIDTH +: ADDR_WIDTH],
                  we[k] ? data[k*DATA_WIDTH +: DATA_WIDTH] : {DATA_WIDTH{1'b0}},
                  pc[k*DATA_WIDTH +: DATA_WIDTH]};
    end
  end

  if (NUM_CORES == 2) begin : g_dmr
    // Detect-only: no majority, no minority, never uncorrectable here.
    always_comb begin
      vote       = '0;
      vote.agree = (tuple[0] == tuple[1]);
    end
  end else begin : g_tmr
    logic eq01, eq02, eq12;

    assign eq01 = (tuple[0] == tuple[1]);
    assign eq02 = (tuple[0] == tuple[2]);
    assign eq12 = (tuple[1] == tuple[2]);

    always_comb begin
      vote               = '0;
      vote.agree         = eq01 & eq12;
      vote.uncorrectable = ~(eq01 | eq02 | eq12);
      // Core 0 is in the majority whenever it matches anyone; otherwise
      // only cores 1 and 2 can form it.
      vote.majority_idx  = (eq01 | eq02) ? 2'd0 : 2'd1;
      if (!vote.agree) begin
        if (eq01)      vote.minority_mask = 3'b100;
        else if (eq02) vote.minority_mask = 3'b010;
        else if (eq12) vote.minority_mask = 3'b001;
        else           vote.minority_mask = 3'b000;
      end
    end
  end

endmodule

// File: rtl/ft_nmr_module.sv
// N-modular-redundancy supervisor for a 2- or 3-core lockstep cluster.
// Votes every cycle's GPR writeback and retired PC, commits agreed writes to
// a shadow GPR file and shadow PC, and on disagreement runs the recovery
// sequence HALT -> RESET -> REPLAY -> RESUME -> RUN.
// Ports:
// - clk_i, rst_i           : clock, synchronous active-high reset
// - we_i/addr_i/data_i/pc_i: packed per-core writeback, core k at slot k
// - halted_i               : per-core halted status
// - halt_o/reset_o/resume_o: core controls
// - replay_valid_o/addr_o/data_o : shadow GPR replay stream
// - spc_o                  : shadow (restart) PC
// - error_o                : one-cycle pulse per detected disagreement
// - fatal_o                : sticky, uncorrectable vote or halt timeout
// - faulty_core_o          : sticky one-hot of outvoted cores (TMR)
// - err_count_o            : saturating disagreement count
// - state_o                : current sequencer state (debug)
module ft_nmr_module
  import ft_pkg::*;
#(
  parameter int                    NUM_CORES    = 3,
  parameter int                    ADDR_WIDTH   = 5,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BOOT_ADDR    = 32'h0000_0080,
  parameter int                    HALT_TIMEOUT = 64,
  parameter int                    CNT_WIDTH    = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_CORES-1:0]            we_i,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] data_i,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] pc_i,
  input  logic [NUM_CORES-1:0]            halted_i,
  output logic                            halt_o,
  output logic                            reset_o,
  output logic                            resume_o,
  output logic                            replay_valid_o,
  output logic [ADDR_WIDTH-1:0]           replay_addr_o,
  output logic [DATA_WIDTH-1:0]           replay_data_o,
  output logic [DATA_WIDTH-1:0]           spc_o,
  output logic                            error_o,
  output logic                            fatal_o,
  output logic [NUM_CORES-1:0]            faulty_core_o,
  output logic [CNT_WIDTH-1:0]            err_count_o,
  output ft_state_e                       state_o
);

  localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
  localparam int                    TMO_W     = $clog2(HALT_TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  ft_state_e             state_q, state_d;
  vote_t                 vote;
  logic [DATA_WIDTH-1:0] shadow_q [DEPTH];
  logic [ADDR_WIDTH-1:0] replay_addr_q;
  logic [TMO_W-1:0]      halt_cnt_q;
  logic                  error_q;
  logic                  fatal_q;
  logic [NUM_CORES-1:0]  faulty_q;
  logic [CNT_WIDTH-1:0]  err_cnt_q;
  logic [DATA_WIDTH-1:0] spc_q;

  ft_voter #(
    .NUM_CORES  (NUM_CORES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_voter (
    .we   (we_i),
    .addr (addr_i),
    .data (data_i),
    .pc   (pc_i),
    .vote (vote)
  );

  // Winning tuple: the agreed one, or the TMR majority.
  logic [1:0]            maj_idx;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [DATA_WIDTH-1:0] sel_pc;

  assign maj_idx  = vote.majority_idx;
  assign sel_we   = we_i[maj_idx];
  assign sel_addr = addr_i[maj_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_data = data_i[maj_idx*DATA_WIDTH +: DATA_WIDTH];
  assign sel_pc   = pc_i[maj_idx*DATA_WIDTH +: DATA_WIDTH];

  logic in_run, mismatch, have_major, commit, halt_timeout;

  // Inputs only matter in RUN; during recovery the cores are not trusted.
  assign in_run     = (state_q == RUN);
  assign mismatch   = in_run & ~vote.agree;
  // A TMR majority still commits in the mismatch cycle; DMR cannot tell
  // which side is right, so it commits only on full agreement.
  assign have_major = vote.agree | ((NUM_CORES == 3) & ~vote.uncorrectable);
  // Writes to x0 are architecturally void and silently dropped.
  assign commit     = in_run & have_major & sel_we & (sel_addr != '0);
  assign halt_timeout = (state_q == HALT) && !(&halted_i) &&
                        (halt_cnt_q == TMO_W'(HALT_TIMEOUT - 1));

  // Sequencer next state and control outputs, all decoded from state_q.
  // The replay stream is valid-only: a beat is presented for exactly one
  // cycle while replay_valid_o=1 and there is no backpressure.
  always_comb begin
    state_d        = state_q;
    halt_o         = 1'b0;
    reset_o        = 1'b0;
    resume_o       = 1'b0;
    replay_valid_o = 1'b0;
    unique case (state_q)
      RUN: begin
        if (!vote.agree) state_d = HALT;
      end
      HALT: begin
        halt_o = 1'b1;
        if ((&halted_i) || halt_timeout) state_d = RESET;
      end
      RESET: begin
        halt_o  = 1'b1;
        reset_o = 1'b1;
        state_d = REPLAY;
      end
      REPLAY: begin
        halt_o         = 1'b1;
        replay_valid_o = 1'b1;
        if (replay_addr_q == LAST_ADDR) state_d = RESUME;
      end
      RESUME: begin
        resume_o = 1'b1;
        state_d  = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign replay_addr_o = replay_valid_o ? replay_addr_q : '0;
  assign replay_data_o = replay_valid_o ? shadow_q[replay_addr_q] : '0;
  assign spc_o         = spc_q;
  assign error_o       = error_q;
  assign fatal_o       = fatal_q;
  assign faulty_core_o = faulty_q;
  assign err_count_o   = err_cnt_q;
  assign state_o       = state_q;

  // Shadow GPR file; x0 is never written and always reads as zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) shadow_q[i] <= '0;
    end else if (commit) begin
      shadow_q[sel_addr] <= sel_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= RUN;
      error_q       <= 1'b0;
      fatal_q       <= 1'b0;
      faulty_q      <= '0;
      err_cnt_q     <= '0;
      spc_q         <= BOOT_ADDR;
      halt_cnt_q    <= '0;
      replay_addr_q <= '0;
    end else begin
      state_q <= state_d;
      error_q <= mismatch;
      if (mismatch && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
      if (in_run && have_major) spc_q <= sel_pc;
      if (mismatch && (NUM_CORES == 3) && !vote.uncorrectable)
        faulty_q <= faulty_q | vote.minority_mask[NUM_CORES-1:0];
      if ((in_run && vote.uncorrectable) || halt_timeout) fatal_q <= 1'b1;
      halt_cnt_q <= (state_q == HALT) ? halt_cnt_q + 1'b1 : '0;
      // x0 is never replayed, so the walk starts at address 1.
      if (state_q == RESET)       replay_addr_q <= ADDR_WIDTH'(1);
      else if (state_q == REPLAY) replay_addr_q <= replay_addr_q + 1'b1;
    end
  end

endmodule
